tick_gen: RTL and testbench

Parametrised multi-channel tick generator: the successor to the fixed four-output clock divider. Each of `N_CH` channels emits a one-cycle strobe every `DIV` input clocks. The divisor is set per channel at elaboration time. All channels share a common enable, a synchronous phase-realign input and a synchronous reset. Downstream timekeeping, blink and display-scan logic consume the strobes as clock enables on `clk`; they are never used as clocks.

---
 rtl/timing_pkg.sv | 31 +++
 rtl/tick_chan.sv | 73 +++++++
 rtl/tick_gen.sv | 47 ++++
 tb/tb_tick_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// rtl/timing_pkg.sv - shared clock-rate and tick divisor constants
//
// Contents:
//   CLK_HZ     system clock rate on clk
//   DIV_1HZ    divisor for a 1 Hz strobe
//   DIV_2HZ    divisor for a 2 Hz strobe
//   DIV_4HZ    divisor for a 4 Hz strobe
//   DIV_400HZ  divisor for a 400 Hz strobe
//   clog2()    ceiling log2, for sizing counters from divisors
package timing_pkg;

  localparam int unsigned CLK_HZ    = 100_000_000;
  localparam int unsigned DIV_1HZ   = CLK_HZ;
  localparam int unsigned DIV_2HZ   = CLK_HZ / 2;
  localparam int unsigned DIV_4HZ   = CLK_HZ / 4;
  localparam int unsigned DIV_400HZ = CLK_HZ / 400;

  // Number of bits needed to count v distinct values (0 for v <= 1).
  function automatic int clog2(input longint unsigned v);
    int              r;
    longint unsigned x;
    r = 0;
    x = (v == 0) ? 64'd0 : v - 64'd1;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// rtl/tick_chan.sv - one divider channel: counter, tick strobe, optional square wave
//
// Parameters:
//   CNT_W  counter width
//   D      divisor; 0 disables the channel, must not exceed 2**CNT_W
// Ports:
//   clk    system clock
//   rst    synchronous reset, active-high
//   en     count enable; counter holds while low
//   sync   synchronous realign; clears the channel like rst
//   tick   one-cycle strobe every D enabled cycles
//   sq     square wave toggling on each tick (constant 0 unless
//          TICK_GEN_SQUARE_EN is defined)
module tick_chan
  import timing_pkg::*;
#(
  parameter int         CNT_W = 27,
  parameter logic [63:0] D    = 64'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync,
  output logic tick,
  output logic sq
);

  localparam bit CH_OFF = (D == 64'd0);
  // Terminal count; D == 2**CNT_W lands on all-ones, which is still correct.
  localparam logic [CNT_W-1:0] D_M1 = CH_OFF ? '0 : CNT_W'(D - 64'd1);

  generate
    if (D > (64'd1 << CNT_W)) begin : g_div_check
      $error("tick_chan: divisor does not fit a CNT_W-bit counter");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic             tick_set;

  // High on the edge that will raise tick.
  assign tick_set = en && !CH_OFF && (cnt == D_M1);

  always_ff @(posedge clk) begin
    if (rst || sync) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en && !CH_OFF) begin
      if (tick_set) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      sq <= 1'b0;
    end else if (tick_set) begin
      sq <= ~sq;
    end
  end
`else
  assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - multi-channel tick generator built from tick_chan copies
//
// Optional feature macro: TICK_GEN_SQUARE_EN (enables the sq square waves).
// Parameters:
//   N_CH      number of channels
//   CNT_W     counter width per channel
//   DIV_LIST  packed divisors, channel i at DIV_LIST[i*CNT_W +: CNT_W]
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   en    global count enable
//   sync  synchronous realign of all channels
//   tick  one-cycle strobe per channel
//   sq    square wave per channel
module tick_gen
  import timing_pkg::*;
#(
  parameter int                    N_CH     = 4,
  parameter int                    CNT_W    = 27,
  parameter logic [N_CH*CNT_W-1:0] DIV_LIST = {CNT_W'(DIV_1HZ), CNT_W'(DIV_4HZ),
                                               CNT_W'(DIV_400HZ), CNT_W'(DIV_2HZ)}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sync,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] sq
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      tick_chan #(
        .CNT_W (CNT_W),
        .D     (64'(DIV_LIST[i*CNT_W +: CNT_W]))
      ) u_chan (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .sync (sync),
        .tick (tick[i]),
        .sq   (sq[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - directed self-checking bench for tick_gen (divisors 4, 7, 1)
module tb_tick_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sync;
  logic [2:0] tick;
  logic [2:0] sq;

  int total;
  int bad;

  tick_gen #(
    .N_CH     (3),
    .CNT_W    (4),
    .DIV_LIST ({4'd1, 4'd7, 4'd4})
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .sync (sync),
    .tick (tick),
    .sq   (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected tick after the m-th enabled edge since reset/realign.
  function automatic logic [2:0] exp_tick(input int m);
    logic [2:0] r;
    r[0] = (m >= 1) && (m % 4 == 0);
    r[1] = (m >= 1) && (m % 7 == 0);
    r[2] = (m >= 1);
    return r;
  endfunction

  // Expected square wave after m enabled edges: toggles once per period.
  function automatic logic [2:0] exp_sq(input int m);
    logic [2:0] r;
`ifdef TICK_GEN_SQUARE_EN
    r[0] = ((m / 4) % 2) == 1;
    r[1] = ((m / 7) % 2) == 1;
    r[2] = (m % 2) == 1;
`else
    r = 3'b000;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    sync = 1'b0;
    en   = 1'b1;
    step();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (tick !== 3'b000) begin
      bad++;
      $display("FAIL reset_tick got=%b want=%b", tick, 3'b000);
    end
    total++;
    if (sq !== 3'b000) begin
      bad++;
      $display("FAIL reset_sq got=%b want=%b", sq, 3'b000);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      step();
      total++;
      if (tick !== exp_tick(n)) begin
        bad++;
        $display("FAIL free_run_tick edge=%0d got=%b want=%b", n, tick, exp_tick(n));
      end
      total++;
      if (sq !== exp_sq(n)) begin
        bad++;
        $display("FAIL free_run_sq edge=%0d got=%b want=%b", n, sq, exp_sq(n));
      end
    end
  endtask

  task automatic test_enable_gap();
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      en = !(n >= 4 && n <= 6);
      step();
      if (n >= 4 && n <= 6) begin
        total++;
        if (tick !== 3'b000) begin
          bad++;
          $display("FAIL gap_tick edge=%0d got=%b want=%b", n, tick, 3'b000);
        end
        total++;
        if (sq !== exp_sq(3)) begin
          bad++;
          $display("FAIL gap_sq_hold edge=%0d got=%b want=%b", n, sq, exp_sq(3));
        end
      end else begin
        total++;
        if (tick !== exp_tick(n > 6 ? n - 3 : n)) begin
          bad++;
          $display("FAIL gap_tick edge=%0d got=%b want=%b", n, tick,
                   exp_tick(n > 6 ? n - 3 : n));
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_sync();
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      sync = (n == 10);
      step();
      total++;
      if (tick !== exp_tick(n >= 10 ? n - 10 : n)) begin
        bad++;
        $display("FAIL sync_tick edge=%0d got=%b want=%b", n, tick,
                 exp_tick(n >= 10 ? n - 10 : n));
      end
      total++;
      if (sq !== exp_sq(n >= 10 ? n - 10 : n)) begin
        bad++;
        $display("FAIL sync_sq edge=%0d got=%b want=%b", n, sq,
                 exp_sq(n >= 10 ? n - 10 : n));
      end
    end
    sync = 1'b0;
  endtask

  task automatic test_reset_on_tick();
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      rst = (n == 8);
      step();
      total++;
      if (tick !== exp_tick(n >= 8 ? n - 8 : n)) begin
        bad++;
        $display("FAIL rst_on_tick edge=%0d got=%b want=%b", n, tick,
                 exp_tick(n >= 8 ? n - 8 : n));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    for (int n = 1; n <= 5; n++) step();
    rst  = 1'b1;
    sync = 1'b1;
    step();
    total++;
    if (tick !== 3'b000 || sq !== 3'b000) begin
      bad++;
      $display("FAIL rst_sync_both got=%b/%b want=000/000", tick, sq);
    end
    rst = 1'b0;
    en  = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      step();
      total++;
      if (tick !== 3'b000 || sq !== 3'b000) begin
        bad++;
        $display("FAIL sync_no_en edge=%0d got=%b/%b want=000/000", n, tick, sq);
      end
    end
    sync = 1'b0;
    en   = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      total++;
      if (tick !== exp_tick(n)) begin
        bad++;
        $display("FAIL after_priority edge=%0d got=%b want=%b", n, tick, exp_tick(n));
      end
    end
  endtask

  task automatic test_square_duty();
    int hi0;
    int hi1;
    do_reset();
    hi0 = 0;
    hi1 = 0;
    for (int n = 1; n <= 56; n++) begin
      step();
      hi0 += int'(sq[0]);
      hi1 += int'(sq[1]);
    end
`ifdef TICK_GEN_SQUARE_EN
    total++;
    if (hi0 != 28) begin
      bad++;
      $display("FAIL sq0_duty got=%0d want=%0d", hi0, 28);
    end
    total++;
    if (hi1 != 28) begin
      bad++;
      $display("FAIL sq1_duty got=%0d want=%0d", hi1, 28);
    end
`else
    total++;
    if (hi0 != 0 || hi1 != 0) begin
      bad++;
      $display("FAIL sq_disabled got=%0d/%0d want=0/0", hi0, hi1);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    en    = 1'b0;
    sync  = 1'b0;
    test_reset();
    test_free_run();
    test_enable_gap();
    test_sync();
    test_reset_on_tick();
    test_priority();
    test_square_duty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
